// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, default configuration, bundle type and the
// halt-trimming helper used by the wide fetch unit.
//   XLEN_DEF / FETCH_WIDTH_DEF / QDEPTH_DEF : default configuration
//   BUNDLE_BYTES / OFFSET_BITS               : bundle geometry for the default
//   fetch_bundle_t                           : {instr, pc, mask} queue entry
//   halt_mask()                              : trims lanes above a halt word
package fetch_pkg;

  localparam int XLEN_DEF        = 32;
  localparam int FETCH_WIDTH_DEF = 2;
  localparam int QDEPTH_DEF      = 4;
  localparam int BUNDLE_BYTES    = FETCH_WIDTH_DEF * 4;
  localparam int OFFSET_BITS     = $clog2(BUNDLE_BYTES);
  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  // Widest supported bundle; the helper works on this width and callers pad.
  localparam int MAX_FW = 8;

  typedef struct packed {
    logic [FETCH_WIDTH_DEF*32-1:0] instr;
    logic [XLEN_DEF-1:0]           pc;
    logic [FETCH_WIDTH_DEF-1:0]    mask;
  } fetch_bundle_t;

  typedef struct packed {
    logic [MAX_FW-1:0] mask;
    logic              hit;
  } halt_result_t;

  // Keep lanes up to and including the lowest valid halt lane; clear the rest.
  function automatic halt_result_t halt_mask(
    input logic [MAX_FW*32-1:0] instr,
    input logic [MAX_FW-1:0]    mask,
    input logic [31:0]          halt_word
  );
    halt_result_t r;
    r.mask = mask;
    r.hit  = 1'b0;
    for (int i = 0; i < MAX_FW; i++) begin
      if (r.hit) begin
        r.mask[i] = 1'b0;
      end else if (mask[i] && (instr[i*32 +: 32] == halt_word)) begin
        r.hit = 1'b1;
      end else begin
        r.hit = r.hit;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: groups the imem request/response bus and the decode-side
// valid/ready bundle channel of the wide fetch unit.
//   master : fetch unit side (drives imem_req/addr and out_*; reads rdata, out_ready)
//   slave  : memory + decode side
interface fetch_if import fetch_pkg::*; #(
  parameter int XLEN        = XLEN_DEF,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEF
);

  logic                      imem_req;
  logic [XLEN-1:0]           imem_addr;
  logic [FETCH_WIDTH*32-1:0] imem_rdata;
  logic                      out_valid;
  logic                      out_ready;
  logic [FETCH_WIDTH*32-1:0] out_instr;
  logic [XLEN-1:0]           out_pc;
  logic [FETCH_WIDTH-1:0]    out_mask;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_mask,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_mask,
    output imem_rdata, out_ready
  );

endinterface

// File: rtl/fetch_bundle_fifo.sv
// fetch_bundle_fifo: synchronous show-ahead FIFO of fetch bundles.
//   clk, rst_n : clock, async active-low reset
//   flush      : empties the queue (wins over push/pop)
//   push, push_data : enqueue one entry
//   pop        : dequeue the head (ignored when empty)
//   head       : current head entry (show-ahead)
//   count, empty, full : occupancy
module fetch_bundle_fifo import fetch_pkg::*; #(
  parameter type T     = fetch_bundle_t,
  parameter int  DEPTH = QDEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  T               mem_q [DEPTH];
  T               mem_d [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           do_push_s, do_pop_s;

  // Next-state computation for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop & (count_q != '0);
    do_push_s = push & ((count_q != FULL_CNT) | do_pop_s);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/fetch_wide.sv
// fetch_wide: multi-issue instruction fetch. Issues bundle-aligned reads to a
// 1-cycle imem, queues returned bundles and presents them to decode.
//   clk, rst_n     : clock, async active-low reset
//   bus (master)   : imem_req/imem_addr/imem_rdata and out_valid/out_ready/
//                    out_instr/out_pc/out_mask
//   redirect_valid, redirect_pc : flush and restart fetch at redirect_pc
//   finish         : sticky, set once the halt bundle has been delivered
module fetch_wide import fetch_pkg::*; #(
  parameter int              XLEN        = XLEN_DEF,
  parameter int              FETCH_WIDTH = FETCH_WIDTH_DEF,
  parameter int              QDEPTH      = QDEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [31:0]     HALT_INSTR  = HALT_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_if.master         bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            finish
);

  localparam int BBYTES = FETCH_WIDTH * 4;
  localparam int CW     = $clog2(QDEPTH);
  localparam logic [XLEN-1:0] OFF_MASK = XLEN'(BBYTES - 1);
  localparam logic [CW:0]     Q_LIMIT  = (CW+1)'(QDEPTH);

  typedef struct packed {
    logic [FETCH_WIDTH*32-1:0] instr;
    logic [XLEN-1:0]           pc;
    logic [FETCH_WIDTH-1:0]    mask;
  } bundle_t;

  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        req_pc_q, req_pc_d;
  logic [FETCH_WIDTH-1:0] start_mask_q, start_mask_d;
  logic [FETCH_WIDTH-1:0] req_mask_q, req_mask_d;
  logic                   started_q, started_d;
  logic                   halted_q, halted_d;
  logic                   inflight_q, inflight_d;
  logic                   finish_q, finish_d;

  logic                   imem_req_s, push_s, pop_s;
  logic [CW:0]            count_s;
  logic                   empty_s, full_s;
  bundle_t                push_bundle_s, head_s;
  logic [MAX_FW*32-1:0]   hm_instr_s;
  logic [MAX_FW-1:0]      hm_mask_s;
  halt_result_t           hm_res_s;
  logic [XLEN-1:0]        redirect_lane_s;
  logic [FETCH_WIDTH-1:0] redirect_mask_s;
  logic                   unused_s;

  // Request / push / pop qualification. The in-flight slot is reserved in the
  // queue so a response can never land on a full queue. A response arriving
  // after halt is dropped: it belongs to fetch past the program end.
  always_comb begin
    imem_req_s = started_q & ~halted_q & ~redirect_valid &
                 (({1'b0, count_s} + {{(CW+1){1'b0}}, inflight_q}) < {1'b0, Q_LIMIT});
    push_s     = inflight_q & ~redirect_valid & ~halted_q;
    pop_s      = ~empty_s & bus.out_ready;
  end

  // Lane mask for the first bundle after a redirect: lanes below the target lane are off.
  always_comb begin
    redirect_lane_s = (redirect_pc & OFF_MASK) >> 2;
    redirect_mask_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      redirect_mask_s[i] = (XLEN'(i) >= redirect_lane_s);
    end
  end

  // Halt trimming of the returning bundle, padded to the helper's width.
  always_comb begin
    hm_instr_s                        = '0;
    hm_instr_s[FETCH_WIDTH*32-1:0]    = bus.imem_rdata;
    hm_mask_s                         = '0;
    hm_mask_s[FETCH_WIDTH-1:0]        = req_mask_q;
    hm_res_s                          = halt_mask(hm_instr_s, hm_mask_s, HALT_INSTR);
    push_bundle_s.instr               = bus.imem_rdata;
    push_bundle_s.pc                  = req_pc_q;
    push_bundle_s.mask                = hm_res_s.mask[FETCH_WIDTH-1:0];
  end

  // Next-state logic for PC, request tracking, halt and finish; redirect wins.
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    start_mask_d = start_mask_q;
    req_mask_d   = req_mask_q;
    started_d    = 1'b1;
    halted_d     = halted_q;
    inflight_d   = inflight_q;
    finish_d     = finish_q;
    if (redirect_valid) begin
      pc_d         = redirect_pc & ~OFF_MASK;
      start_mask_d = redirect_mask_s;
      halted_d     = 1'b0;
      finish_d     = 1'b0;
      inflight_d   = 1'b0;
    end else begin
      inflight_d = imem_req_s;
      if (imem_req_s) begin
        req_pc_d     = pc_q & ~OFF_MASK;
        req_mask_d   = start_mask_q;
        start_mask_d = '1;
        pc_d         = pc_q + XLEN'(BBYTES);
      end else begin
        pc_d = pc_q;
      end
      if (push_s && hm_res_s.hit) begin
        halted_d = 1'b1;
      end else begin
        halted_d = halted_q;
      end
      // Once halted nothing more is pushed, so the last entry is the halt bundle.
      if (pop_s && halted_q && (count_s == (CW+1)'(1))) begin
        finish_d = 1'b1;
      end else begin
        finish_d = finish_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      start_mask_q <= '1;
      req_mask_q   <= '1;
      started_q    <= 1'b0;
      halted_q     <= 1'b0;
      inflight_q   <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      start_mask_q <= start_mask_d;
      req_mask_q   <= req_mask_d;
      started_q    <= started_d;
      halted_q     <= halted_d;
      inflight_q   <= inflight_d;
      finish_q     <= finish_d;
    end
  end

  fetch_bundle_fifo #(
    .T     (bundle_t),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_bundle_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  // Decode-side outputs; zero while the queue is empty.
  always_comb begin
    if (empty_s) begin
      bus.out_instr = '0;
      bus.out_pc    = '0;
      bus.out_mask  = '0;
    end else begin
      bus.out_instr = head_s.instr;
      bus.out_pc    = head_s.pc;
      bus.out_mask  = head_s.mask;
    end
  end

  assign bus.out_valid = ~empty_s;
  assign bus.imem_req  = imem_req_s;
  assign bus.imem_addr = pc_q & ~OFF_MASK;
  assign finish        = finish_q;
  assign unused_s      = ^{hm_res_s, full_s};

endmodule

// File: tb/tb_fetch_wide.sv
// tb_fetch_wide: directed bench for fetch_wide. Instance A uses FETCH_WIDTH=2,
// QDEPTH=4; instance B uses FETCH_WIDTH=4, QDEPTH=8. Each imem model returns
// word = address (A optionally places a halt word at 0x10).
module tb_fetch_wide;

  logic        clk;
  logic        rst_n;
  logic        a_redir_v, b_redir_v;
  logic [31:0] a_redir_pc, b_redir_pc;
  logic        a_finish, b_finish;
  logic        halt_en;
  int          checks;
  int          failures;

  fetch_if #(.XLEN(32), .FETCH_WIDTH(2)) a_if ();
  fetch_if #(.XLEN(32), .FETCH_WIDTH(4)) b_if ();

  fetch_wide #(
    .XLEN(32), .FETCH_WIDTH(2), .QDEPTH(4),
    .RESET_PC(32'h0000_0000), .HALT_INSTR(32'hFFFF_FFFF)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if),
    .redirect_valid(a_redir_v), .redirect_pc(a_redir_pc), .finish(a_finish)
  );

  fetch_wide #(
    .XLEN(32), .FETCH_WIDTH(4), .QDEPTH(8),
    .RESET_PC(32'h0000_0000), .HALT_INSTR(32'hFFFF_FFFF)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if),
    .redirect_valid(b_redir_v), .redirect_pc(b_redir_pc), .finish(b_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_a(input logic [31:0] ad);
    return (halt_en && (ad == 32'h10)) ? 32'hFFFF_FFFF : ad;
  endfunction

  // 1-cycle imem models.
  always @(posedge clk) begin
    if (a_if.imem_req)
      a_if.imem_rdata <= {word_a(a_if.imem_addr + 32'd4), word_a(a_if.imem_addr)};
    if (b_if.imem_req)
      b_if.imem_rdata <= {b_if.imem_addr + 32'd12, b_if.imem_addr + 32'd8,
                          b_if.imem_addr + 32'd4, b_if.imem_addr};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; before the edge confirm no push lands on a full queue.
  task automatic cyc();
    #1;
    if (rst_n === 1'b1) begin
      chk("no_push_full_a", 64'(dut_a.u_fifo.push & dut_a.u_fifo.full), 64'h0);
      chk("no_push_full_b", 64'(dut_b.u_fifo.push & dut_b.u_fifo.full), 64'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    halt_en = 1'b0;
    a_redir_v = 1'b0; a_redir_pc = 32'h0;
    b_redir_v = 1'b0; b_redir_pc = 32'h0;
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    #2;
    // Reset state
    chk("rst_out_valid", 64'(a_if.out_valid), 64'h0);
    chk("rst_imem_req", 64'(a_if.imem_req), 64'h0);
    chk("rst_out_pc", 64'(a_if.out_pc), 64'h0);
    chk("rst_out_mask", 64'(a_if.out_mask), 64'h0);
    chk("rst_out_instr", 64'(a_if.out_instr), 64'h0);
    chk("rst_finish", 64'(a_finish), 64'h0);
    chk("rst_b_out_valid", 64'(b_if.out_valid), 64'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("not_started_req", 64'(a_if.imem_req), 64'h0);

    // 1. Sequential fetch
    cyc();
    chk("seq_req0", 64'(a_if.imem_req), 64'h1);
    chk("seq_addr0", 64'(a_if.imem_addr), 64'h0);
    chk("seq_valid_early", 64'(a_if.out_valid), 64'h0);
    cyc();
    chk("seq_addr1", 64'(a_if.imem_addr), 64'h8);
    chk("seq_valid_lat", 64'(a_if.out_valid), 64'h0);
    cyc();
    chk("seq_valid0", 64'(a_if.out_valid), 64'h1);
    chk("seq_pc0", 64'(a_if.out_pc), 64'h0);
    chk("seq_mask0", 64'(a_if.out_mask), 64'h3);
    chk("seq_instr0", 64'(a_if.out_instr), 64'h0000_0004_0000_0000);
    chk("seq_addr2", 64'(a_if.imem_addr), 64'h10);
    cyc();
    chk("seq_pc1", 64'(a_if.out_pc), 64'h8);
    chk("seq_instr1", 64'(a_if.out_instr), 64'h0000_000C_0000_0008);
    chk("seq_addr3", 64'(a_if.imem_addr), 64'h18);
    cyc();
    chk("seq_pc2", 64'(a_if.out_pc), 64'h10);
    chk("seq_mask2", 64'(a_if.out_mask), 64'h3);

    // 2. Backpressure
    a_if.out_ready = 1'b0;
    reset_pulse();
    cycn(10);
    chk("bp_count", 64'(dut_a.u_fifo.count), 64'h4);
    chk("bp_req", 64'(a_if.imem_req), 64'h0);
    chk("bp_head", 64'(a_if.out_pc), 64'h0);
    a_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("bp_drain_valid", 64'(a_if.out_valid), 64'h1);
      chk("bp_drain_pc", 64'(a_if.out_pc), 64'(8 * k));
      chk("bp_drain_instr", 64'(a_if.out_instr[31:0]), 64'(8 * k));
      cyc();
    end

    // 3. Redirect with 3 queued bundles and one in flight
    a_if.out_ready = 1'b0;
    reset_pulse();
    cycn(5);
    chk("rd_pre_count", 64'(dut_a.u_fifo.count), 64'h3);
    chk("rd_pre_inflight", 64'(dut_a.inflight_q), 64'h1);
    a_redir_v = 1'b1;
    a_redir_pc = 32'h104;
    #1;
    chk("rd_req_blocked", 64'(a_if.imem_req), 64'h0);
    cyc();
    a_redir_v = 1'b0;
    #1;
    chk("rd_flushed", 64'(a_if.out_valid), 64'h0);
    chk("rd_req", 64'(a_if.imem_req), 64'h1);
    chk("rd_addr", 64'(a_if.imem_addr), 64'h100);
    cyc();
    chk("rd_no_old", 64'(a_if.out_valid), 64'h0);
    chk("rd_addr2", 64'(a_if.imem_addr), 64'h108);
    cyc();
    chk("rd_first_valid", 64'(a_if.out_valid), 64'h1);
    chk("rd_first_pc", 64'(a_if.out_pc), 64'h100);
    chk("rd_first_mask", 64'(a_if.out_mask), 64'h2);
    chk("rd_first_instr", 64'(a_if.out_instr), 64'h0000_0104_0000_0100);
    cyc();
    chk("rd_stall_pc", 64'(a_if.out_pc), 64'h100);
    chk("rd_stall_mask", 64'(a_if.out_mask), 64'h2);
    a_if.out_ready = 1'b1;
    cyc();
    chk("rd_second_pc", 64'(a_if.out_pc), 64'h108);
    chk("rd_second_mask", 64'(a_if.out_mask), 64'h3);

    // 4. Halt
    halt_en = 1'b1;
    reset_pulse();
    cycn(4);
    chk("h_pc8", 64'(a_if.out_pc), 64'h8);
    cyc();
    chk("h_pc10", 64'(a_if.out_pc), 64'h10);
    chk("h_mask", 64'(a_if.out_mask), 64'h1);
    chk("h_req_stop", 64'(a_if.imem_req), 64'h0);
    chk("h_finish_early", 64'(a_finish), 64'h0);
    cyc();
    chk("h_finish", 64'(a_finish), 64'h1);
    chk("h_drained", 64'(a_if.out_valid), 64'h0);
    chk("h_req_stop2", 64'(a_if.imem_req), 64'h0);
    cyc();
    chk("h_finish_sticky", 64'(a_finish), 64'h1);
    chk("h_no_extra", 64'(a_if.out_valid), 64'h0);
    a_redir_v = 1'b1;
    a_redir_pc = 32'h0;
    #1;
    chk("h_finish_redir_cycle", 64'(a_finish), 64'h1);
    cyc();
    a_redir_v = 1'b0;
    #1;
    chk("h_finish_cleared", 64'(a_finish), 64'h0);
    chk("h_resume_req", 64'(a_if.imem_req), 64'h1);
    chk("h_resume_addr", 64'(a_if.imem_addr), 64'h0);
    cycn(4);
    chk("h2_mask", 64'(a_if.out_mask), 64'h1);
    cyc();
    chk("h2_finish", 64'(a_finish), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_finish_now", 64'(a_finish), 64'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;

    // 5. Async reset with a full queue
    halt_en = 1'b0;
    a_if.out_ready = 1'b0;
    cycn(10);
    chk("ar_full", 64'(dut_a.u_fifo.count), 64'h4);
    chk("ar_valid_pre", 64'(a_if.out_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_now", 64'(a_if.out_valid), 64'h0);
    chk("ar_req_now", 64'(a_if.imem_req), 64'h0);
    chk("ar_finish_0", 64'(a_finish), 64'h0);
    chk("ar_pc_now", 64'(a_if.out_pc), 64'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("ar_req_unstarted", 64'(a_if.imem_req), 64'h0);
    cyc();
    chk("ar_req_restart", 64'(a_if.imem_req), 64'h1);
    chk("ar_addr_restart", 64'(a_if.imem_addr), 64'h0);

    // 6. FETCH_WIDTH=4, QDEPTH=8 redirect
    b_redir_v = 1'b1;
    b_redir_pc = 32'h20C;
    #1;
    chk("w4_req_blocked", 64'(b_if.imem_req), 64'h0);
    cyc();
    b_redir_v = 1'b0;
    #1;
    chk("w4_req", 64'(b_if.imem_req), 64'h1);
    chk("w4_addr", 64'(b_if.imem_addr), 64'h200);
    chk("w4_flushed", 64'(b_if.out_valid), 64'h0);
    cyc();
    chk("w4_addr2", 64'(b_if.imem_addr), 64'h210);
    cyc();
    chk("w4_valid", 64'(b_if.out_valid), 64'h1);
    chk("w4_pc0", 64'(b_if.out_pc), 64'h200);
    chk("w4_mask0", 64'(b_if.out_mask), 64'h8);
    chk("w4_lane3", 64'(b_if.out_instr[127:96]), 64'h20C);
    cyc();
    chk("w4_pc1", 64'(b_if.out_pc), 64'h210);
    chk("w4_mask1", 64'(b_if.out_mask), 64'hF);
    cyc();
    chk("w4_pc2", 64'(b_if.out_pc), 64'h220);
    chk("w4_mask2", 64'(b_if.out_mask), 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_wide.md
Name: fetch_wide

Overview:
Parametrised multi-issue instruction fetch unit. It supersedes the fixed two-instruction Fetch and sits between the instruction memory and decode. It issues bundle-aligned requests to a 1-cycle-latency imem, buffers returned bundles in a show-ahead queue, and presents them to decode over a valid/ready handshake. It also supports branch redirect (flush) and halt detection, which drives a sticky finish.

Parameters:
XLEN, 32, address/PC width
FETCH_WIDTH, 2, instructions per bundle (power of 2, 1..8)
QDEPTH, 4, bundle queue entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, PC after reset (bundle-aligned)
HALT_INSTR, 32'hFFFF_FFFF, encoding that terminates fetch

Ports:
clk  in  1  clock
rst_n  in  1  reset
imem_req  out  1  read request this cycle
imem_addr  out  XLEN  bundle-aligned request address
imem_rdata  in  FETCH_WIDTH*32  bundle data, valid exactly 1 cycle after imem_req; lane i = word at addr+4i
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  XLEN  new PC (bits[1:0] ignored)
out_valid  out  1  head bundle available
out_ready  in  1  decode accepts head bundle
out_instr  out  FETCH_WIDTH*32  head bundle instructions, lane 0 in LSBs
out_pc  out  XLEN  address of lane 0 of head bundle
out_mask  out  FETCH_WIDTH  valid lanes of head bundle
finish  out  1  program halted and fully delivered

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Reset clears the queue (count=0), pc=RESET_PC, halted=0, inflight=0, started=0, finish=0, and start mask = all ones. imem_req, out_valid, out_instr, out_pc and out_mask read 0. Assertion mid-operation takes effect immediately; any in-flight response is discarded.
- started sets on the first clk edge after rst_n rises. imem_req is held 0 until then.
- Request: imem_req = started & !halted & !redirect_valid & (count + inflight < QDEPTH), where inflight is a 1-bit flag set for the cycle after a request. imem_addr = pc aligned down to FETCH_WIDTH*4. On request, pc += FETCH_WIDTH*4.
- Response: the cycle after a request, {imem_rdata, pc, mask} is pushed unless a redirect occurred in the request cycle or the response cycle (squash).
- Mask: the first bundle after a redirect masks off lanes below redirect_pc[log2(FETCH_WIDTH*4)-1:2]. All later bundles start with all lanes valid.
- Halt: if any valid lane equals HALT_INSTR, lanes above the lowest such lane are masked off; the halt lane itself stays valid. halted is set on the push edge, so no further requests issue.
- Output: show-ahead from the queue head. out_valid = (count != 0). The pop occurs on out_valid & out_ready. out_* are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: count unchanged. Push into a full queue cannot occur by construction; the bench asserts this.
- Pop with empty queue: ignored.
- finish: set on the edge after the bundle containing the halt lane is popped. It is sticky until reset or redirect.
- Redirect (priority over all): on the edge with redirect_valid=1:
  - queue count=0; the in-flight response is squashed;
  - halted=0 and finish=0;
  - pc = {redirect_pc aligned to bundle} and the start mask is computed;
  - first new request is the next cycle.
- PC arithmetic wraps modulo 2^XLEN.

Decomposition:
- Package fetch_pkg:
  - constant BUNDLE_BYTES = FETCH_WIDTH*4 and OFFSET_BITS = log2(BUNDLE_BYTES);
  - typedef fetch_bundle_t {logic [FETCH_WIDTH*32-1:0] instr; logic [XLEN-1:0] pc; logic [FETCH_WIDTH-1:0] mask};
  - function halt_mask(instr, mask) returning the trimmed mask and a hit flag.
- Sub-module fetch_bundle_fifo: a synchronous show-ahead FIFO of fetch_bundle_t, depth QDEPTH, with flush, push, pop, count, empty and full. The top level holds the PC, request control, squash, halt and finish logic.

Test Plan:
1. Sequential fetch: FETCH_WIDTH=2, imem returns word=addr, out_ready=1 -> imem_addr 0x0,0x8,0x10...; out_pc 0x0,0x8,0x10; out_mask 2'b11; first out_valid 2 cycles after the first imem_req.
2. Backpressure: out_ready=0 for 10 cycles -> count reaches 4, imem_req stays 0, head stays at pc 0x0. Release -> bundles 0x0..0x18 are popped in order with no gaps and no duplicates.
3. Redirect: redirect_pc=0x104 while the queue holds 3 entries and a request is in flight -> out_valid=0 the next cycle; next imem_addr=0x100; first bundle out_pc=0x100, out_mask=2'b10; no bundle from the old stream appears.
4. Halt: word at 0x10 = 32'hFFFF_FFFF -> bundle 0x10 has out_mask=2'b01; imem_req stays 0 afterwards; finish=1 one cycle after that pop. A subsequent redirect to 0x0 clears finish and fetch resumes.
5. Async reset mid-stream: rst_n=0 between clock edges with a full queue -> out_valid, imem_req and finish are 0 immediately. After release, the first imem_addr=RESET_PC.
6. FETCH_WIDTH=4, QDEPTH=8 instance: redirect to 0x20C -> imem_addr 0x200, out_mask 4'b1000; later bundles 4'b1111 at 0x210, 0x220.
